mitchell_div: RTL and testbench
===============================

Name: mitchell_div

Overview:
- Pipelined Mitchell approximate divider; the inverse operation of the team's Mitchell log multiplier.
- Inputs use the same 9-bit one's-complement signed encoding as the multiplier.
- Datapath: each operand is converted to a log word, the divisor log is subtracted from the dividend log, and the antilog is taken to produce a signed Q8.8 quotient.
- Sits beside the multiplier in the approximate-arithmetic datapath, behind a valid/ready stream interface.

Parameters:
- WIDTH, 8, operand magnitude width; operand port width is WIDTH+1.
- FRAC, 8, number of fractional bits in the quotient magnitude.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  1  operand pair valid.
- ready_o  out  1  block accepts operands this cycle.
- a_i  in  WIDTH+1  dividend, one's-complement; magnitude = a_i[7:0] ^ {8{a_i[8]}}.
- b_i  in  WIDTH+1  divisor, same encoding.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- q_o  out  1+WIDTH+FRAC (17)  quotient, one's-complement signed Q8.8.
- div_zero_o  out  1  divisor magnitude was zero; qualified by valid_o.

Behaviour:
- Reset (rst_i high at an edge):
  - All stage valid bits cleared.
  - valid_o=0, q_o=0, div_zero_o=0.
  - ready_o=0 while rst_i is high.
  - Reset mid-operation flushes every in-flight operation with no output.
- Pipeline control:
  - Three register stages, latency 3 cycles from an accepted input to valid_o.
  - Single global advance enable: en = ~valid_o | ready_i; ready_o = en & ~rst_i.
  - Transfer in when valid_i & ready_o; transfer out when valid_o & ready_i.
  - All stages shift together when en=1. Bubbles are not collapsed; throughput is 1 per cycle.
  - When en=0, every stage register and all outputs hold stable.
- Stage 1 (log encode, per operand):
  - magnitude M = low 8 bits XOR sign.
  - k = index of leading one (0..7).
  - f = 7-bit fraction = (M << (7-k))[6:0].
  - Register {k,f} for each operand, zero flags zA and zB, and sign s = a_i[8]^b_i[8].
- Stage 2 (log subtract):
  - L = {0,kA,fA} - {0,kB,fB}, an 11-bit two's-complement value in Q4.7.
  - e = L[10:7] as signed (range -8..7); fL = L[6:0]. The borrow from the fraction is absorbed into e by the subtraction.
  - Register L, zA, zB, s.
- Stage 3 (antilog):
  - Place mantissa {1,fL} at Q8.8 bit positions [8:1].
  - Shift left by e if e>=0; shift right by -e if e<0. Bits below 2^-8 are truncated.
  - Range: e=7 cannot overflow 16 bits; e=-8 yields 16'h0001.
- Special cases, priority top-down:
  - zB=1: div_zero_o=1, magnitude 16'hFFFF, sign applied.
  - zA=1: magnitude 0, sign forced 0, so q_o=17'h00000 and never the -0 encoding.
  - Otherwise: div_zero_o=0.
- Output: q_o = {17{s}} ^ {1'b0, magnitude}.
- Both -0 encodings (9'h1FF and 9'h000) count as zero.

Decomposition:
- Package mitchell_pkg holds:
  - WIDTH, FRAC, K_W=$clog2(WIDTH), LOG_W=K_W+WIDTH-1+1.
  - The log-word struct {k, f}.
  - The one's-complement magnitude function.
- Sub-module mitchell_log_enc: magnitude in; k, f and zero flag out. Combinational; instantiated twice in stage 1, and reusable by the multiplier.
- Antilog shift stays inline in mitchell_div.

Test Plan:
- Exact powers: a=6 (9'h006), b=3 → 3 cycles later q_o=17'h00200 (2.0), div_zero_o=0. a=3, b=6 → 17'h00080 (0.5).
- Mitchell error: a=5, b=3 → q_o=17'h001C0 (1.75). a=7, b=2 → 17'h00380 (3.5). a=1, b=255 → 17'h00001.
- Signs and zero: a=9'h1F9 (-6), b=3 → 17'h1FDFF. a=9'h1FF (-0), b=9'h1FA → 17'h00000, div_zero_o=0.
- Divide by zero: a=5, b=0 → q_o=17'h0FFFF, div_zero_o=1. a=9'h1FA, b=0 → 17'h10000, div_zero_o=1.
- Backpressure: stream 6 back-to-back pairs with ready_i low for cycles 4-7.
  - valid_o and q_o hold stable while ready_i is low.
  - ready_o=0 while stalled.
  - All 6 results appear in order with no loss or duplication.
- Reset mid-stream: rst_i high for 1 cycle with 3 operations in flight → valid_o=0 the next cycle. No stale result ever emerges. The first post-reset input produces a result after exactly 3 cycles.

Source files
------------

// File: rtl/mitchell_pkg.sv
// mitchell_pkg: shared widths, log-word type and one's-complement magnitude helper
package mitchell_pkg;
    localparam int WIDTH = 8;
    localparam int FRAC = 8;
    localparam int K_W = $clog2(WIDTH);
    localparam int LOG_W = K_W + WIDTH - 1 + 1;
    typedef struct packed {
        logic [K_W-1:0] k;
        logic [WIDTH-2:0] f;
    } log_t;
    function automatic logic [WIDTH-1:0] oc_mag(input logic [WIDTH:0] x);
        return x[WIDTH-1:0] ^ {WIDTH{x[WIDTH]}};
    endfunction
endpackage

// File: rtl/mitchell_log_enc.sv
// mitchell_log_enc: magnitude -> Mitchell log word {k, f}
// ports: mag (unsigned magnitude), lw (leading-one index and 7-bit fraction), zero (mag == 0)
module mitchell_log_enc
    import mitchell_pkg::*;
(
    input  logic [WIDTH-1:0] mag,
    output log_t             lw,
    output logic             zero
);
    logic [K_W-1:0] k;
    logic [WIDTH-1:0] sh;
    always_comb begin
        k = '0;
        for (int i = 0; i < WIDTH; i++) k = mag[i] ? K_W'(i) : k;
        sh = mag << (K_W'(WIDTH - 1) - k);
        lw.k = k;
        lw.f = sh[WIDTH-2:0];
        zero = mag == '0;
    end
endmodule

// File: rtl/mitchell_div.sv
// mitchell_div: 3-stage pipelined Mitchell approximate divider, one's-complement Q8.8 quotient
// ports: clk_i, rst_i (sync, active-high); valid_i/ready_o/a_i/b_i operand stream;
//        valid_o/ready_i/q_o/div_zero_o result stream
module mitchell_div
    import mitchell_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [WIDTH:0]        a_i,
    input  logic [WIDTH:0]        b_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [WIDTH+FRAC:0]   q_o,
    output logic                  div_zero_o
);
    localparam int Q_W = WIDTH + FRAC;
    logic en;
    log_t la, lb, la_r, lb_r;
    logic za, zb;
    logic v1, za1, zb1, s1;
    logic v2, za2, zb2, s2;
    logic [LOG_W-1:0] l_d, l2;
    logic [K_W:0] e;
    logic [Q_W-1:0] mant, sh, mag;
    logic sg;

    assign en = ~valid_o | ready_i;
    assign ready_o = en & ~rst_i;

    mitchell_log_enc u_enc_a (.mag(oc_mag(a_i)), .lw(la), .zero(za));
    mitchell_log_enc u_enc_b (.mag(oc_mag(b_i)), .lw(lb), .zero(zb));

    // the fraction borrow propagates into the exponent field naturally
    assign l_d = {1'b0, la_r} - {1'b0, lb_r};

    always_comb begin
        e = l2[LOG_W-1:WIDTH-1];
        mant = {{(FRAC - 1){1'b0}}, 1'b1, l2[WIDTH-2:0], 1'b0};
        // e is a 4-bit two's-complement exponent; -e wraps 1000 to 8 as a shift amount
        sh = e[K_W] ? mant >> (-e) : mant << e;
        mag = zb2 ? '1 : za2 ? '0 : sh;
        sg = s2 & (zb2 | ~za2);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            valid_o <= 1'b0;
            q_o <= '0;
            div_zero_o <= 1'b0;
        end else if (en) begin
            v1 <= valid_i;
            la_r <= la;
            lb_r <= lb;
            za1 <= za;
            zb1 <= zb;
            s1 <= a_i[WIDTH] ^ b_i[WIDTH];
            v2 <= v1;
            l2 <= l_d;
            za2 <= za1;
            zb2 <= zb1;
            s2 <= s1;
            valid_o <= v2;
            q_o <= {(Q_W + 1){sg}} ^ {1'b0, mag};
            div_zero_o <= zb2;
        end
    end
endmodule

// File: tb/tb_mitchell_div.sv
// tb_mitchell_div: scoreboard bench for mitchell_div
module tb_mitchell_div;
    logic clk = 0, rst_i = 1, valid_i = 0, ready_i = 1;
    logic ready_o, valid_o, div_zero_o;
    logic [8:0] a_i = '0, b_i = '0;
    logic [16:0] q_o;
    logic [17:0] sb[$];
    logic [17:0] exp_r;
    int n_chk = 0, n_fail = 0;

    mitchell_div dut (.clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .valid_o(valid_o), .ready_i(ready_i), .q_o(q_o),
        .div_zero_o(div_zero_o));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [17:0] model(input logic [8:0] a, input logic [8:0] b);
        int ma, mb, ka, kb, la, lb, d, ex, fl, m;
        ma = int'(a[7:0] ^ {8{a[8]}});
        mb = int'(b[7:0] ^ {8{b[8]}});
        if (mb == 0) return {1'b1, {17{a[8] ^ b[8]}} ^ 17'h0FFFF};
        if (ma == 0) return 18'h0;
        ka = 0;
        kb = 0;
        for (int i = 0; i < 8; i++) begin
            if (ma >= (1 << i)) ka = i;
            if (mb >= (1 << i)) kb = i;
        end
        la = ka * 128 + (((ma - (1 << ka)) * 128) >> ka);
        lb = kb * 128 + (((mb - (1 << kb)) * 128) >> kb);
        d = la - lb;
        ex = d >>> 7;
        fl = d - ex * 128;
        m = (ex + 1 >= 0) ? (128 + fl) << (ex + 1) : (128 + fl) >> (-(ex + 1));
        return {1'b0, {17{a[8] ^ b[8]}} ^ {1'b0, m[15:0]}};
    endfunction

    task automatic send(input logic [8:0] a, input logic [8:0] b, input logic [17:0] e);
        bit done = 0;
        a_i = a;
        b_i = b;
        valid_i = 1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (ready_o) begin
                sb.push_back(e);
                done = 1;
            end
            @(posedge clk);
        end
        if (!done) check("send_timeout", 0, 1);
        #1 valid_i = 0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
        check("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_i && valid_o && ready_i) begin
            if (sb.size() == 0) check("stale_result", 1, 0);
            else begin
                exp_r = sb.pop_front();
                check("q", q_o, exp_r[16:0]);
                check("div_zero", div_zero_o, exp_r[17]);
            end
        end
    end

    logic [16:0] held_q;
    logic held_v;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_q", q_o, 0);
        check("rst_dz", div_zero_o, 0);
        @(posedge clk);
        #1 rst_i = 0;

        send(9'h006, 9'h003, 18'h00200);
        send(9'h003, 9'h006, 18'h00080);
        send(9'h005, 9'h003, 18'h001C0);
        send(9'h007, 9'h002, 18'h00380);
        send(9'h001, 9'h0FF, 18'h00001);
        send(9'h1F9, 9'h003, 18'h1FDFF);
        send(9'h1FF, 9'h1FA, 18'h00000);
        send(9'h000, 9'h000, 18'h2FFFF);
        send(9'h005, 9'h000, 18'h2FFFF);
        send(9'h1FA, 9'h000, 18'h30000);
        send(9'h0FF, 9'h001, model(9'h0FF, 9'h001));
        drain();
        for (int i = 0; i < 20; i++) begin
            logic [8:0] a, b;
            a = 9'($urandom);
            b = 9'($urandom);
            send(a, b, model(a, b));
        end
        drain();

        fork
            for (int i = 0; i < 6; i++) begin
                logic [8:0] a, b;
                a = 9'($urandom);
                b = 9'($urandom_range(1, 255));
                send(a, b, model(a, b));
            end
            begin
                for (int t = 0; t < 50 && !valid_o; t++) @(posedge clk);
                #1 ready_i = 0;
                @(negedge clk);
                held_q = q_o;
                held_v = valid_o;
                check("bp_valid", held_v, 1);
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("bp_hold_valid", valid_o, held_v);
                    check("bp_hold_q", q_o, held_q);
                    check("bp_ready", ready_o, 0);
                end
                @(posedge clk);
                #1 ready_i = 1;
            end
        join
        drain();

        for (int i = 0; i < 3; i++) send(9'h006, 9'h003, 18'h00200);
        rst_i = 1;
        sb.delete();
        @(negedge clk);
        check("rst_mid_ready", ready_o, 0);
        @(posedge clk);
        #1 rst_i = 0;
        check("rst_mid_valid", valid_o, 0);
        check("rst_mid_q", q_o, 0);
        repeat (5) @(posedge clk);
        #1;
        send(9'h007, 9'h002, 18'h00380);
        @(negedge clk);
        check("lat_c1", valid_o, 0);
        @(negedge clk);
        check("lat_c2", valid_o, 0);
        @(negedge clk);
        check("lat_c3", valid_o, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
